// File: rtl/heater_adc_scheduler.sv
// Round-robin scheduler that time-shares one 12-bit thermistor ADC across NUM_CH heater
// channels, publishing per-channel readings and forcing faulted channels to a safe zero.
module heater_adc_scheduler #(
    parameter int          NUM_CH         = 2,
    parameter int          SETTLE_CYCLES  = 64,
    parameter int          TIMEOUT_CYCLES = 4096,
    parameter logic [11:0] LOW_LIM        = 12'd16,
    parameter logic [11:0] HIGH_LIM       = 12'd4080,
    localparam int         CW             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [NUM_CH-1:0]    ch_mask,
    input  logic [NUM_CH-1:0]    fault_clr,
    output logic [CW-1:0]        adc_sel,
    output logic                 adc_start,
    input  logic                 adc_done,
    input  logic [11:0]          adc_data,
    output logic [NUM_CH*12-1:0] temp_out,
    output logic [NUM_CH-1:0]    temp_valid,
    output logic [NUM_CH-1:0]    fault,
    output logic                 busy
);

    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_START,
        ST_WAIT,
        ST_STORE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CW-1:0]    sel;
    logic [CW-1:0]    rr_ptr;
    logic [CW-1:0]    rr_nxt;
    logic [CW-1:0]    cand;
    logic [CW-1:0]    next_sel;
    logic             next_found;
    logic [11:0]      data_q;
    logic             go;
    logic             timeout;
    logic             store_en;
    logic             store_fault;

    // Search starts at rr_ptr (one past the last serviced channel), wrapping.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        next_sel   = rr_ptr;
        next_found = 1'b0;
        cand       = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = CW'((int'(rr_ptr) + k) % NUM_CH);
            if (!next_found && ch_mask[cand]) begin
                next_found = 1'b1;
                next_sel   = cand;
            end
        end
    end

    assign rr_nxt  = CW'((int'(sel) + 1) % NUM_CH);
    assign go      = enable && next_found;
    assign timeout = (state == ST_WAIT) && !adc_done && (cnt == TIMEOUT_LAST);

    always_comb begin
        store_en    = 1'b0;
        store_fault = 1'b0;
        if (state == ST_STORE) begin
            store_en    = 1'b1;
            store_fault = (data_q <= LOW_LIM) || (data_q >= HIGH_LIM);
        end else if (timeout) begin
            store_en    = 1'b1;
            store_fault = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register
        // samples pre-edge values regardless of statement order.
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (go) state_nxt = ST_SETTLE;
            ST_SETTLE: if (cnt == SETTLE_LAST) state_nxt = ST_START;
            ST_START:  state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (adc_done)     state_nxt = ST_STORE;
                else if (timeout) state_nxt = ST_IDLE;
            end
            ST_STORE:  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every register here is a small flop, so all of them are reset; nothing
        // in this block is a memory array that would need to stay unreset.
        if (rst) begin
            cnt        <= '0;
            sel        <= '0;
            rr_ptr     <= '0;
            data_q     <= '0;
            temp_out   <= '0;
            temp_valid <= '0;
            fault      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        sel <= next_sel;
                        cnt <= '0;
                    end
                end
                ST_SETTLE: cnt <= cnt + 1'b1;
                ST_START:  cnt <= '0;
                ST_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (adc_done) data_q <= adc_data;
                end
                default: ;
            endcase

            if (store_en) rr_ptr <= rr_nxt;

            // A faulted channel holds zero; the clear and a new fault may coincide, set wins.
            for (int i = 0; i < NUM_CH; i++) begin
                temp_valid[i] <= store_en && (sel == CW'(i));
                fault[i]      <= (fault[i] && !fault_clr[i]) ||
                                 (store_en && (sel == CW'(i)) && store_fault);
                if (store_en && (sel == CW'(i))) begin
                    temp_out[i*12 +: 12] <= (store_fault || fault[i]) ? 12'd0 : data_q;
                end
            end
        end
    end

    assign adc_sel   = sel;
    assign adc_start = (state == ST_START);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_heater_adc_scheduler.sv
// Scoreboard bench: stimulus queues expected readings, a monitor checks each temp_valid pulse.
module tb_heater_adc_scheduler;

    localparam int NUM_CH  = 2;
    localparam int CW      = 1;
    localparam int SETTLE  = 64;
    localparam int TIMEOUT = 4096;
    localparam int CONV    = 20;
    localparam int LAT_OK  = 1 + SETTLE + 1 + CONV + 1;
    localparam int LAT_TO  = 1 + SETTLE + 1 + TIMEOUT;

    logic                 clk;
    logic                 rst;
    logic                 enable;
    logic [NUM_CH-1:0]    ch_mask;
    logic [NUM_CH-1:0]    fault_clr;
    logic [CW-1:0]        adc_sel;
    logic                 adc_start;
    logic                 adc_done;
    logic [11:0]          adc_data;
    logic [NUM_CH*12-1:0] temp_out;
    logic [NUM_CH-1:0]    temp_valid;
    logic [NUM_CH-1:0]    fault;
    logic                 busy;

    heater_adc_scheduler #(
        .NUM_CH        (NUM_CH),
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TIMEOUT),
        .LOW_LIM       (12'd16),
        .HIGH_LIM      (12'd4080)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .ch_mask   (ch_mask),
        .fault_clr (fault_clr),
        .adc_sel   (adc_sel),
        .adc_start (adc_start),
        .adc_done  (adc_done),
        .adc_data  (adc_data),
        .temp_out  (temp_out),
        .temp_valid(temp_valid),
        .fault     (fault),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [11:0] temp;
        logic        flt;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          sel_log[$];
    int          passed    = 0;
    int          total     = 0;
    int          cyc       = 0;
    int          starts    = 0;
    int          valid_cnt = 0;
    int          rise_cyc  = 0;
    logic        busy_q    = 1'b0;
    logic [11:0] adc_val [NUM_CH];
    bit          no_done [NUM_CH];
    int          mdl_sel;
    exp_t        mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        else passed++;
    endtask

    task automatic push(input int ch, input int temp, input bit flt, input int lat);
        exp_t e;
        e.ch   = ch;
        e.temp = 12'(temp);
        e.flt  = flt;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((busy || sb.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_in_time"}, 32'(n < budget), 1);
    endtask

    task automatic run_n(input string name, input int n);
        int base = starts;
        int k    = 0;
        enable = 1'b1;
        while (starts < base + n && k < 20000) begin
            @(negedge clk);
            k++;
        end
        enable = 1'b0;
        wait_idle(name, 12000);
        check({name, "_starts"}, 32'(starts - base), 32'(n));
    endtask

    task automatic pulse_clr(input logic [NUM_CH-1:0] m);
        fault_clr = m;
        @(negedge clk);
        fault_clr = '0;
    endtask

    task automatic check_sels(input string name, input int e0, input int e1, input int e2, input int cnt);
        int exp_sel[3];
        exp_sel = '{e0, e1, e2};
        check({name, "_nsel"}, 32'(sel_log.size()), 32'(cnt));
        for (int i = 0; i < cnt; i++)
            check({name, "_sel"}, (i < sel_log.size()) ? 32'(sel_log[i]) : 32'hFFFF_FFFF, 32'(exp_sel[i]));
    endtask

    initial forever @(posedge clk) cyc++;

    // ADC model: done arrives CONV cycles after the start pulse unless muted for that channel.
    initial begin
        adc_done = 1'b0;
        adc_data = '0;
        forever begin
            @(negedge clk);
            if (adc_start) begin
                mdl_sel = int'(adc_sel);
                starts++;
                sel_log.push_back(mdl_sel);
                if (!no_done[mdl_sel]) begin
                    repeat (CONV) @(posedge clk);
                    #1;
                    adc_done = 1'b1;
                    adc_data = adc_val[mdl_sel];
                    @(posedge clk);
                    #1;
                    adc_done = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (temp_valid != '0) begin
                valid_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_valid", 32'(temp_valid), 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("valid_ch", 32'(temp_valid), 32'(1 << mon_e.ch));
                    check("temp", 32'(temp_out[mon_e.ch*12 +: 12]), 32'(mon_e.temp));
                    check("fault", 32'(fault[mon_e.ch]), 32'(mon_e.flt));
                    if (mon_e.lat != 0) check("latency", 32'(cyc - rise_cyc + 1), 32'(mon_e.lat));
                end
            end
            if (busy && !busy_q) rise_cyc = cyc;
            busy_q = busy;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        int s2;
        int v0;
        rst       = 1'b1;
        enable    = 1'b0;
        ch_mask   = '0;
        fault_clr = '0;
        adc_val   = '{12'd2000, 12'd1500};
        no_done   = '{0, 0};
        repeat (3) @(negedge clk);
        check("rst_temp_out", 32'(temp_out), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_sel", 32'(adc_sel), 0);
        check("rst_start", 32'(adc_start), 0);
        check("rst_valid", 32'(temp_valid), 0);
        rst = 1'b0;
        @(negedge clk);

        // Empty mask: scheduler must stay idle.
        enable = 1'b1;
        repeat (20) @(negedge clk);
        check("mask0_busy", 32'(busy), 0);
        check("mask0_starts", 32'(starts), 0);
        enable = 1'b0;

        // 1: alternate both channels.
        ch_mask = 2'b11;
        sel_log.delete();
        push(0, 2000, 0, LAT_OK);
        push(1, 1500, 0, LAT_OK);
        push(0, 2000, 0, LAT_OK);
        run_n("t1", 3);
        check_sels("t1", 0, 1, 0, 3);
        check("t1_temp_out", 32'(temp_out), 32'({12'd1500, 12'd2000}));

        // 2: only channel 1 rotates.
        ch_mask = 2'b10;
        sel_log.delete();
        push(1, 1500, 0, LAT_OK);
        push(1, 1500, 0, LAT_OK);
        push(1, 1500, 0, LAT_OK);
        run_n("t2", 3);
        check_sels("t2", 1, 1, 1, 3);

        // 3: channel 0 never answers -> timeout fault, then channel 1.
        ch_mask = 2'b11;
        no_done[0] = 1;
        sel_log.delete();
        push(0, 0, 1, LAT_TO);
        push(1, 1500, 0, LAT_OK);
        run_n("t3", 2);
        check_sels("t3", 0, 1, 0, 2);
        check("t3_fault", 32'(fault), 32'(2'b01));
        check("t3_temp_out", 32'(temp_out), 32'({12'd1500, 12'd0}));
        no_done[0] = 0;
        pulse_clr(2'b01);
        check("t3_fault_clr", 32'(fault), 0);

        // 4: open sensor on channel 1, sticky zero, then recovery after clear.
        ch_mask = 2'b10;
        adc_val[1] = 12'd4080;
        push(1, 0, 1, 0);
        run_n("t4a", 1);
        adc_val[1] = 12'd2000;
        push(1, 0, 1, 0);
        run_n("t4b", 1);
        check("t4_fault_held", 32'(fault), 32'(2'b10));
        pulse_clr(2'b10);
        check("t4_fault_clr", 32'(fault), 0);
        push(1, 2000, 0, 0);
        run_n("t4c", 1);
        check("t4_temp1", 32'(temp_out[23:12]), 2000);

        // Low-limit boundary on channel 0: 16 faults, 17 and 4079 pass.
        ch_mask = 2'b01;
        adc_val[0] = 12'd16;
        push(0, 0, 1, 0);
        run_n("lo16", 1);
        pulse_clr(2'b01);
        adc_val[0] = 12'd17;
        push(0, 17, 0, 0);
        run_n("lo17", 1);
        adc_val[0] = 12'd4079;
        push(0, 4079, 0, 0);
        run_n("hi4079", 1);
        check("bound_fault", 32'(fault), 0);

        // 5: reset during WAIT, stray done afterwards must be ignored.
        ch_mask = 2'b11;
        adc_val[0] = 12'd2000;
        base = starts;
        k = 0;
        enable = 1'b1;
        while (starts == base && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("t5_started", 32'(starts - base), 1);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_temp", 32'(temp_out), 0);
        check("t5_rst_busy", 32'(busy), 0);
        rst = 1'b0;
        v0 = valid_cnt;
        repeat (40) @(negedge clk);
        check("t5_no_valid", 32'(valid_cnt - v0), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_fault", 32'(fault), 0);
        check("t5_sel", 32'(adc_sel), 0);

        // 6: enable dropped during SETTLE -> this conversion completes, no more starts.
        push(0, 2000, 0, LAT_OK);
        base = starts;
        k = 0;
        enable = 1'b1;
        while (!busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("t6_busy_rise", 32'(busy), 1);
        repeat (10) @(negedge clk);
        enable = 1'b0;
        wait_idle("t6", 2000);
        check("t6_one_start", 32'(starts - base), 1);
        s2 = starts;
        repeat (200) @(negedge clk);
        check("t6_no_more_starts", 32'(starts - s2), 0);
        check("t6_idle", 32'(busy), 0);

        check("sb_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/heater_adc_scheduler.md
Name: heater_adc_scheduler

Overview:
Time-shares one 12-bit thermistor ADC between NUM_CH heater channels (extruder, bed, ...) and feeds each channel's heater_control temp input.
- Round-robin sequencing: analog mux select, settle wait, ADC start/done handshake, per-channel result registers.
- Flags timed-out conversions and out-of-range (open/shorted thermistor) readings.
- Fault-safe output: a faulted channel's output is forced to 0, which heater_control interprets as "hotter than target", so the heater is switched off.

Parameters:
- NUM_CH, 2, number of thermistor channels (1..8).
- SETTLE_CYCLES, 64, clk cycles waited after a mux change before start (>=1).
- TIMEOUT_CYCLES, 4096, max clk cycles from adc_start to adc_done before timeout fault.
- LOW_LIM, 12'd16, readings <= LOW_LIM are a sensor fault (shorted).
- HIGH_LIM, 12'd4080, readings >= HIGH_LIM are a sensor fault (open).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  scheduler runs while high.
- ch_mask  in  NUM_CH  bit i=1 includes channel i in the rotation.
- fault_clr  in  NUM_CH  bit i=1 (level) clears fault[i].
- adc_sel  out  CW=max(1,$clog2(NUM_CH))  analog mux channel select.
- adc_start  out  1  one-cycle conversion start pulse.
- adc_done  in  1  one-cycle pulse; adc_data is valid in the same cycle.
- adc_data  in  12  conversion result.
- temp_out  out  NUM_CH*12  channel i occupies bits [12i+11:12i].
- temp_valid  out  NUM_CH  one-cycle pulse when channel i is updated.
- fault  out  NUM_CH  sticky fault per channel.
- busy  out  1  high in any state other than IDLE.

Behaviour:
Reset (async, applies immediately): all outputs and state to zero; state IDLE; rr pointer = 0.

States:
- IDLE: if enable && |ch_mask, select the next channel in rotation; set adc_sel; clear the counter; go to SETTLE. Otherwise stay.
- Next-channel search: first masked index strictly after the last serviced index, wrapping modulo NUM_CH. With a single masked channel, that channel is re-selected.
- SETTLE: count SETTLE_CYCLES cycles, then go to START.
- START: adc_start=1 for exactly one cycle; counter cleared; go to WAIT.
- WAIT: counter increments each cycle.
  - adc_done: capture adc_data; go to STORE.
  - Counter reaches TIMEOUT_CYCLES-1 without done: fault[sel]=1; temp_out[sel]=0; temp_valid[sel] pulses; rr pointer advances; go to IDLE.
- STORE (one cycle):
  - In range (LOW_LIM < data < HIGH_LIM): temp_out[sel]=data.
  - Out of range: fault[sel]=1 and temp_out[sel]=0.
  - In both cases: temp_valid[sel] pulses; rr pointer advances; go to IDLE.

Timing:
- adc_sel is stable from entry to SETTLE until leaving STORE or timeout.
- Latency from IDLE selection to temp_valid = 1 + SETTLE_CYCLES + 1 + conversion cycles + 1.

Fault handling:
- While fault[i]=1, temp_out[i] stays 0 and in-range conversions do not overwrite it. The channel keeps rotating, so recovery is observable after the clear.
- fault_clr[i] clears fault[i]. If a new fault sets in the same cycle, set wins.

Boundary cases:
- enable deasserted mid-sequence: the current conversion completes normally; the block returns to IDLE and stays there.
- ch_mask change mid-sequence: takes effect at the next IDLE selection. The current channel finishes even if it was unmasked.
- ch_mask == 0: stay in IDLE; busy=0.
- adc_done outside WAIT: ignored.
- rst mid-conversion: state to IDLE. Outputs and faults are cleared; a stale adc_done after reset is ignored.
- Exact limits: data == LOW_LIM or data == HIGH_LIM is a fault.

Test Plan:
1. NUM_CH=2, mask=2'b11, ADC model returns 12'd2000 for ch0 and 12'd1500 for ch1 after 20 cycles -> adc_sel alternates 0,1,0; temp_out={1500,2000}. Exactly one temp_valid pulse per conversion, arriving 1+64+1+20+1 cycles after selection.
2. mask=2'b10 -> only ch1 is converted repeatedly; temp_valid[0] is never asserted; adc_sel stays 1.
3. ADC never returns done on ch0 -> after 4096 WAIT cycles: fault[0]=1, temp_out[0]=0, temp_valid[0] pulses; scheduler proceeds to ch1.
4. adc_data 12'd4080 on ch1 -> fault[1]=1, temp_out[1]=0. A following 12'd2000 leaves temp_out[1]=0. After fault_clr[1] for one cycle, the next 12'd2000 gives temp_out[1]=2000 with fault[1]=0.
5. rst pulsed during WAIT, then adc_done arrives -> all outputs 0, state IDLE, the stray done produces no temp_valid.
6. enable dropped during SETTLE -> that conversion completes and stores; busy falls after STORE; no further adc_start pulses.
